// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and helpers for the three-master memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

   // Master indices
   localparam logic [1:0] ARB_M_JTAG = 2'd0;
   localparam logic [1:0] ARB_M_EX   = 2'd1;
   localparam logic [1:0] ARB_M_IF   = 2'd2;

   // Arbiter state codes
   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   // Next master index in the fixed ring 0 -> 1 -> 2 -> 0
   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx >= ARB_M_IF) ? ARB_M_JTAG : idx + 2'd1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick3.sv
// Round-robin picker: first requester after `last` in ring order 0,1,2.
// Latency: combinational.
// Backpressure: none; valid simply reports that some request is present.
module rr_pick3
   import mem_port_arbiter_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   output logic       valid,
   output logic [1:0] idx
);

   logic [3:0] req_x;
   logic [1:0] c0, c1, c2;

   assign req_x = {1'b0, req};

   // Walk the ring starting just after the previous winner
   always_comb begin
      c0    = rr_next(last);
      c1    = rr_next(c0);
      c2    = rr_next(c1);
      valid = |req;
      idx   = ARB_M_JTAG;
      if (req_x[c0])      idx = c0;
      else if (req_x[c1]) idx = c1;
      else if (req_x[c2]) idx = c2;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one slave port among jtag (m0), ex (m1) and ifu (m2); optional abort via ARB_TIMEOUT_EN.
// Latency: req sampled at edge k -> s_req_o in cycle k+1; ack combinational with s_ack_i.
// Backpressure: one transaction in flight; other masters wait, hold_flag_o freezes the core.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic [DATA_W-1:0] m0_rdata_o,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   input  logic              m2_req_i,
   input  logic              m2_we_i,
   input  logic [ADDR_W-1:0] m2_addr_i,
   input  logic [DATA_W-1:0] m2_wdata_i,
   output logic [DATA_W-1:0] m2_rdata_o,
   output logic              m2_ack_o,
   output logic              m2_err_o,
   output logic              s_req_o,
   output logic              s_we_o,
   output logic [ADDR_W-1:0] s_addr_o,
   output logic [DATA_W-1:0] s_wdata_o,
   input  logic [DATA_W-1:0] s_rdata_i,
   input  logic              s_ack_i,
   output logic              hold_flag_o
);

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("mem_port_arbiter: TIMEOUT must be at least 1");
   end

   arb_state_t        state, state_nx;
   logic [1:0]        grant, last;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              pick_vld;
   logic [1:0]        pick_idx;
   logic              start, done, abort;
   logic [2:0]        ack_v, err_v;
   logic [DATA_W-1:0] rdata_v [3];

   rr_pick3 u_pick (
      .req   ({m2_req_i, m1_req_i, m0_req_i}),
      .last  (last),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   assign start = (state == ARB_IDLE) && pick_vld;
   assign done  = (state == ARB_BUSY) && s_ack_i;

`ifdef ARB_TIMEOUT_EN
   localparam int                 CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT);
   logic [CNT_W-1:0]              cnt;

   // Count BUSY cycles without an ack; held at zero while idle so each transaction starts fresh
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                   cnt <= '0;
      else if (state == ARB_IDLE) cnt <= '0;
      else if (!s_ack_i)          cnt <= cnt + 1'b1;
   end

   assign abort = (state == ARB_BUSY) && !s_ack_i && (cnt == CNT_MAX);
`else
   assign abort = 1'b0;
`endif

   // Mux the winning master's command for latching
   always_comb begin
      sel_we    = m0_we_i;
      sel_addr  = m0_addr_i;
      sel_wdata = m0_wdata_i;
      case (pick_idx)
         ARB_M_EX: begin
            sel_we    = m1_we_i;
            sel_addr  = m1_addr_i;
            sel_wdata = m1_wdata_i;
         end
         ARB_M_IF: begin
            sel_we    = m2_we_i;
            sel_addr  = m2_addr_i;
            sel_wdata = m2_wdata_i;
         end
         default: ;
      endcase
   end

   // State register plus grant bookkeeping and command latches
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ARB_IDLE;
         grant     <= ARB_M_JTAG;
         last      <= ARB_M_IF;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else begin
         state <= state_nx;
         if (start) begin
            grant     <= pick_idx;
            last      <= pick_idx;
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
         end
      end
   end

   // Next state, slave command and per-master completion
   always_comb begin
      state_nx  = state;
      s_req_o   = 1'b0;
      s_we_o    = 1'b0;
      s_addr_o  = '0;
      s_wdata_o = '0;
      ack_v     = '0;
      err_v     = '0;
      for (int i = 0; i < 3; i++) rdata_v[i] = '0;
      case (state)
         ARB_IDLE: if (start) state_nx = ARB_BUSY;
         ARB_BUSY: begin
            s_req_o   = 1'b1;
            s_we_o    = lat_we;
            s_addr_o  = lat_addr;
            s_wdata_o = lat_wdata;
            if (done || abort) state_nx = ARB_IDLE;
            for (int i = 0; i < 3; i++) begin
               if ((done || abort) && grant == 2'(i)) begin
                  ack_v[i]   = 1'b1;
                  err_v[i]   = abort;
                  rdata_v[i] = done ? s_rdata_i : '0;
               end
            end
         end
         default: state_nx = ARB_IDLE;
      endcase
   end

   assign m0_ack_o   = ack_v[0];
   assign m1_ack_o   = ack_v[1];
   assign m2_ack_o   = ack_v[2];
   assign m0_err_o   = err_v[0];
   assign m1_err_o   = err_v[1];
   assign m2_err_o   = err_v[2];
   assign m0_rdata_o = rdata_v[0];
   assign m1_rdata_o = rdata_v[1];
   assign m2_rdata_o = rdata_v[2];

   // Core masters still waiting for their ack stall the pipeline
   assign hold_flag_o = (m1_req_i & ~m1_ack_o) | (m2_req_i & ~m2_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed sequences, grant table, random vs model.
// Latency: n/a.
// Backpressure: slave ack driven directly by the bench.
module tb_mem_port_arbiter;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  req, we, ack, err;
   logic [31:0] addr [3];
   logic [31:0] wdata [3];
   logic [31:0] rdata [3];
   logic        s_req, s_we, s_ack, hold;
   logic [31:0] s_addr, s_wdata, s_rdata;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]), .m0_wdata_i(wdata[0]),
      .m0_rdata_o(rdata[0]), .m0_ack_o(ack[0]), .m0_err_o(err[0]),
      .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]), .m1_wdata_i(wdata[1]),
      .m1_rdata_o(rdata[1]), .m1_ack_o(ack[1]), .m1_err_o(err[1]),
      .m2_req_i(req[2]), .m2_we_i(we[2]), .m2_addr_i(addr[2]), .m2_wdata_i(wdata[2]),
      .m2_rdata_o(rdata[2]), .m2_ack_o(ack[2]), .m2_err_o(err[2]),
      .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
      .s_rdata_i(s_rdata), .s_ack_i(s_ack), .hold_flag_o(hold)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      for (int m = 0; m < 3; m++) begin
         req[m] = 1'b0; we[m] = 1'b0; addr[m] = '0; wdata[m] = '0;
      end
      s_ack = 1'b0;
      s_rdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      tick();
      tick();
      rst = 1'b1;
   endtask

   typedef struct {
      logic [2:0] mask;
      int         exp;
   } row_t;
   row_t tbl [12];

   // Reference model state (transaction-level view of the arbiter)
   bit          m_busy;
   int          m_g, m_last, m_n;
   logic        m_we;
   logic [31:0] m_addr, m_wdata;
   bit   [2:0]  eack, eerr, prev_ack;
   logic [31:0] erd [3];
   bit          fin, to_hit, found;
   int          pulses;

   initial begin
      // Grant order from reset (last=2); each row is one transaction
      tbl[0]  = '{3'b111, 0}; tbl[1]  = '{3'b111, 1}; tbl[2]  = '{3'b111, 2};
      tbl[3]  = '{3'b111, 0}; tbl[4]  = '{3'b101, 2}; tbl[5]  = '{3'b011, 0};
      tbl[6]  = '{3'b110, 1}; tbl[7]  = '{3'b100, 2}; tbl[8]  = '{3'b010, 1};
      tbl[9]  = '{3'b001, 0}; tbl[10] = '{3'b011, 1}; tbl[11] = '{3'b101, 2};

      // Reset state
      clear_inputs();
      @(negedge clk);
      chk("rst_sreq", 32'(s_req), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_hold0", 32'(hold), 0);
      req[1] = 1'b1;
      #1;
      chk("rst_hold_eq", 32'(hold), 1);
      chk("rst_sreq_req", 32'(s_req), 0);
      req[1] = 1'b0;
      tick();
      rst = 1'b1;

      // m2 single read, immediate ack
      req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h100;
      @(negedge clk);
      chk("t1_idle_sreq", 32'(s_req), 0);
      chk("t1_hold_wait", 32'(hold), 1);
      tick();
      s_ack = 1'b1; s_rdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("t1_sreq", 32'(s_req), 1);
      chk("t1_addr", s_addr, 32'h100);
      chk("t1_ack", 32'(ack), 3'b100);
      chk("t1_rdata", rdata[2], 32'hDEADBEEF);
      chk("t1_rdata_m0", rdata[0], 0);
      chk("t1_hold_done", 32'(hold), 0);
      tick();
      req[2] = 1'b0; s_ack = 1'b0;
      @(negedge clk);
      chk("t1_sreq_drop", 32'(s_req), 0);
      chk("t1_ack_drop", 32'(ack), 0);

      // m1 write, ack in the 4th BUSY cycle; address input changes mid-flight
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h2000; wdata[1] = 32'hA5A5A5A5;
      tick();
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         s_ack = (i == 3);
         if (i == 1) begin addr[1] = 32'hFFFF0000; wdata[1] = 32'h0; we[1] = 1'b0; end
         @(negedge clk);
         chk("t3_sreq", 32'(s_req), 1);
         chk("t3_addr", s_addr, 32'h2000);
         chk("t3_wdata", s_wdata, 32'hA5A5A5A5);
         chk("t3_we", 32'(s_we), 1);
         chk("t3_ack", 32'(ack), (i == 3) ? 32'h2 : 32'h0);
         chk("t3_hold", 32'(hold), (i == 3) ? 32'h0 : 32'h1);
         if (ack[1]) pulses++;
         tick();
      end
      req[1] = 1'b0; s_ack = 1'b0;
      @(negedge clk);
      if (ack[1]) pulses++;
      chk("t3_pulses", 32'(pulses), 1);

      // Grant table from a fresh reset
      do_reset();
      for (int r = 0; r < 12; r++) begin
         for (int m = 0; m < 3; m++) begin
            req[m] = tbl[r].mask[m]; we[m] = 1'b0; addr[m] = 32'h1000 * (m + 1) + 32'(r);
         end
         @(negedge clk);
         chk("tbl_idle", 32'(s_req), 0);
         chk("tbl_hold_wait", 32'(hold), 32'(tbl[r].mask[1] | tbl[r].mask[2]));
         tick();
         s_ack = 1'b1; s_rdata = 32'hC0DE0000 + 32'(r);
         @(negedge clk);
         chk("tbl_addr", s_addr, 32'h1000 * (tbl[r].exp + 1) + 32'(r));
         chk("tbl_ack", 32'(ack), 32'(1) << tbl[r].exp);
         chk("tbl_rdata", rdata[tbl[r].exp], 32'hC0DE0000 + 32'(r));
         chk("tbl_hold", 32'(hold),
             32'((tbl[r].mask[1] && tbl[r].exp != 1) || (tbl[r].mask[2] && tbl[r].exp != 2)));
         tick();
         s_ack = 1'b0;
      end
      clear_inputs();

      // Async reset mid-BUSY, then m1 wins over m2
      req[0] = 1'b1; addr[0] = 32'h3000;
      tick();
      req[1] = 1'b1; addr[1] = 32'h4000;
      req[2] = 1'b1; addr[2] = 32'h5000;
      @(negedge clk);
      chk("t4_busy", 32'(s_req), 1);
      chk("t4_busy_addr", s_addr, 32'h3000);
      #2;
      rst = 1'b0; s_ack = 1'b1;
      #1;
      chk("t4_rst_sreq", 32'(s_req), 0);
      chk("t4_rst_ack", 32'(ack), 0);
      chk("t4_rst_addr", s_addr, 0);
      chk("t4_rst_hold", 32'(hold), 1);
      @(posedge clk);
      #1;
      rst = 1'b1; req[0] = 1'b0; s_ack = 1'b0;
      @(negedge clk);
      chk("t4_idle", 32'(s_req), 0);
      tick();
      s_ack = 1'b1; s_rdata = 32'h11;
      @(negedge clk);
      chk("t4_first_m1", 32'(ack), 3'b010);
      chk("t4_first_addr", s_addr, 32'h4000);
      tick();
      req[1] = 1'b0; s_ack = 1'b0;
      tick();
      s_ack = 1'b1;
      @(negedge clk);
      chk("t4_then_m2", 32'(ack), 3'b100);
      tick();
      clear_inputs();

      // Slave never acks
      do_reset();
      req[2] = 1'b1; addr[2] = 32'h100;
      tick();
      s_rdata = 32'h12345678;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
`ifdef ARB_TIMEOUT_EN
         if (i < TO + 1) begin
            chk("t5_wait_sreq", 32'(s_req), 1);
            chk("t5_wait_ack", 32'(ack), 0);
         end else if (i == TO + 1) begin
            chk("t5_abort_ack", 32'(ack), 3'b100);
            chk("t5_abort_err", 32'(err), 3'b100);
            chk("t5_abort_rdata", rdata[2], 0);
         end else begin
            chk("t5_stray_ack", 32'(ack), 0);
            chk("t5_stray_sreq", 32'(s_req), 0);
         end
         tick();
         if (i == TO + 1) req[2] = 1'b0;
         if (i >= TO + 1) s_ack = 1'b1;
`else
         chk("t6_sreq", 32'(s_req), 1);
         chk("t6_ack", 32'(ack), 0);
         chk("t6_err", 32'(err), 0);
         tick();
`endif
      end

      // Random traffic against the reference model
      do_reset();
      m_busy = 0; m_g = 0; m_last = 2; m_n = 0;
      m_we = 0; m_addr = 0; m_wdata = 0; prev_ack = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int m = 0; m < 3; m++) begin
            if (req[m] && prev_ack[m]) req[m] = 1'b0;
            else if (!req[m] && $urandom_range(0, 3) == 0) begin
               req[m] = 1'b1; we[m] = 1'($urandom_range(0, 1));
               addr[m] = $urandom; wdata[m] = $urandom;
            end
         end
         s_ack = ($urandom_range(0, 2) == 0);
         s_rdata = $urandom;
`ifdef ARB_TIMEOUT_EN
         to_hit = m_busy && !s_ack && (m_n == TO + 1);
`else
         to_hit = 0;
`endif
         fin = m_busy && (s_ack || to_hit);
         eack = 0; eerr = 0;
         for (int m = 0; m < 3; m++) begin
            erd[m] = 0;
            if (fin && m == m_g) begin
               eack[m] = 1; eerr[m] = to_hit; erd[m] = s_ack ? s_rdata : 32'h0;
            end
         end
         @(negedge clk);
         chk("rnd_sreq", 32'(s_req), 32'(m_busy));
         chk("rnd_ack", 32'(ack), 32'(eack));
         chk("rnd_err", 32'(err), 32'(eerr));
         for (int m = 0; m < 3; m++) chk("rnd_rdata", rdata[m], erd[m]);
         chk("rnd_hold", 32'(hold), 32'((req[1] && !eack[1]) || (req[2] && !eack[2])));
         if (m_busy) begin
            chk("rnd_addr", s_addr, m_addr);
            chk("rnd_wdata", s_wdata, m_wdata);
            chk("rnd_we", 32'(s_we), 32'(m_we));
         end
         // Advance the model across the coming edge
         if (m_busy) begin
            if (fin) m_busy = 0;
            else m_n++;
         end else begin
            found = 0;
            for (int k = 1; k <= 3; k++) begin
               if (!found && req[(m_last + k) % 3]) begin
                  found = 1; m_g = (m_last + k) % 3;
               end
            end
            if (found) begin
               m_last = m_g; m_busy = 1; m_n = 1;
               m_we = we[m_g]; m_addr = addr[m_g]; m_wdata = wdata[m_g];
            end
         end
         prev_ack = eack;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
